// File: rtl/psum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psum_pkg
//  Description : Shared definitions for the psum merge stage. Holds the
//                writer mode encodings and the width-generic saturating
//                adder that the merge datapath uses.
//  Revision    : 1.0 - initial release
// ============================================================================
package psum_pkg;

    // Writer mode encodings
    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_ACC   = 2'd1;
    localparam logic [1:0] MODE_DRAIN = 2'd2;
    localparam logic [1:0] MODE_HOLD  = 2'd3;

    // Internal working width of sat_add. Operands must be sign-extended to
    // this width and hold values of at most c_SAT_W-1 bits, so the raw sum
    // never overflows the working width.
    localparam int c_SAT_W = 64;

    // Signed add of two w-bit values carried in c_SAT_W-bit containers.
    // With sat set, the result is clamped to the w-bit signed range.
    // Otherwise the raw sum is returned, and the caller keeps the low w bits,
    // which gives the wrapping result.
    function automatic logic signed [c_SAT_W-1:0] sat_add(
        input logic signed [c_SAT_W-1:0] a,
        input logic signed [c_SAT_W-1:0] b,
        input int unsigned               w,
        input logic                      sat
    );
        logic signed [c_SAT_W-1:0] sum;
        logic signed [c_SAT_W-1:0] hi;
        logic signed [c_SAT_W-1:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (w - 1));
        if (sat && (sum > hi)) begin
            sat_add = hi;
        end else if (sat && (sum < lo)) begin
            sat_add = lo;
        end else begin
            sat_add = sum;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/psum_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : psum_fifo
//  Description : Synchronous count-based FIFO. It takes one word per write
//                and returns RD_PAR words per read, with the oldest word in
//                the LSBs. With FWFT=1, o_dout shows the head words
//                combinationally. Otherwise o_dout is registered and is
//                updated only by a read that succeeds.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst  : clock, synchronous active-high reset
//    i_wen     : push i_din. Ignored when no slot is free after this cycle's read.
//    i_din     : word to push
//    i_ren     : pop RD_PAR words. Ignored when fewer than RD_PAR are stored.
//    o_dout    : popped words (registered) or head words (FWFT)
//    o_count   : words currently stored
// ============================================================================
module psum_fifo #(
    parameter int WIDTH  = 33,
    parameter int DEPTH  = 64,
    parameter int RD_PAR = 1,
    parameter int FWFT   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_wen,
    input  logic [WIDTH-1:0]          i_din,
    input  logic                      i_ren,
    output logic [RD_PAR*WIDTH-1:0]   o_dout,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0]        r_mem [DEPTH];
    logic [c_AW-1:0]         r_wr_ptr;
    logic [c_AW-1:0]         r_rd_ptr;
    logic [c_CW-1:0]         r_count;
    logic [c_CW-1:0]         w_rd_cnt;
    logic                    w_rd;
    logic                    w_wr;
    logic [RD_PAR*WIDTH-1:0] w_rd_words;

    assign w_rd     = i_ren & (r_count >= c_CW'(RD_PAR));
    assign w_rd_cnt = w_rd ? c_CW'(RD_PAR) : '0;
    // A read in the same cycle frees its slots, so a push into a full
    // FIFO still lands when it is paired with a pop.
    assign w_wr     = i_wen & ((r_count - w_rd_cnt) < c_CW'(DEPTH));

    // The pointers are log2(DEPTH) wide, so the address wraps on its own.
    for (genvar k = 0; k < RD_PAR; k++) begin : g_rd_word
        assign w_rd_words[k*WIDTH +: WIDTH] = r_mem[r_rd_ptr + c_AW'(k)];
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(RD_PAR);
            end
            r_count <= r_count + c_CW'(w_wr) - w_rd_cnt;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign o_dout = w_rd_words;
    end else begin : g_reg_dout
        logic [RD_PAR*WIDTH-1:0] r_dout;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_dout <= '0;
            end else if (w_rd) begin
                r_dout <= w_rd_words;
            end
        end
        assign o_dout = r_dout;
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/psum_accum_outbuf.sv
`default_nettype none
// ============================================================================
//  Module      : psum_accum_outbuf
//  Description : Output-side psum merge stage. Each PE psum is either passed
//                through or added to the head of the input-psum FIFO. In
//                drain mode, input psums are forwarded unchanged. Results go
//                through one pipe register into the output FIFO.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst                : clock, synchronous active-high reset
//    mode                    : 0 pass, 1 accumulate, 2 drain inpsum, 3 hold
//    psum_valid/_in/_ready   : PE psum handshake
//    inpsum_wen/_din         : input-psum push
//    inpsum_full/_empty      : input-psum FIFO status
//    outbuf_ren              : pop OUT_PAR result words
//    outbuf_dout             : popped words, oldest in the LSBs (registered)
//    outbuf_full/_empty      : no room for another result / < OUT_PAR stored
//    out_count               : words stored in the output FIFO
// ============================================================================
module psum_accum_outbuf
    import psum_pkg::*;
#(
    parameter int PSUM_WIDTH = 33,
    parameter int IN_DEPTH   = 64,
    parameter int OUT_DEPTH  = 64,
    parameter int OUT_PAR    = 1,
    parameter int SATURATE   = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      mode,
    input  logic                            psum_valid,
    input  logic [PSUM_WIDTH-1:0]           psum_in,
    output logic                            psum_ready,
    input  logic                            inpsum_wen,
    input  logic [PSUM_WIDTH-1:0]           inpsum_din,
    output logic                            inpsum_full,
    output logic                            inpsum_empty,
    input  logic                            outbuf_ren,
    output logic [OUT_PAR*PSUM_WIDTH-1:0]   outbuf_dout,
    output logic                            outbuf_full,
    output logic                            outbuf_empty,
    output logic [$clog2(OUT_DEPTH):0]      out_count
);

    localparam int c_ICW = $clog2(IN_DEPTH) + 1;
    localparam int c_OCW = $clog2(OUT_DEPTH) + 1;

    logic [c_ICW-1:0]      w_in_count;
    logic [PSUM_WIDTH-1:0] w_in_head;
    logic [PSUM_WIDTH-1:0] w_sum;
    logic [PSUM_WIDTH-1:0] w_load_data;
    logic                  w_room;
    logic                  w_load;
    logic                  w_pop;
    logic                  r_pipe_valid;
    logic [PSUM_WIDTH-1:0] r_pipe_data;

    assign inpsum_empty = (w_in_count == '0);
    assign inpsum_full  = (w_in_count == c_ICW'(IN_DEPTH));

    // The in-flight pipe entry has a reserved slot, so it can always be
    // written. A read in the same cycle does not make room until the
    // following cycle.
    assign w_room       = (out_count + c_OCW'(r_pipe_valid)) < c_OCW'(OUT_DEPTH);
    assign outbuf_full  = ~w_room;
    assign outbuf_empty = out_count < c_OCW'(OUT_PAR);

    assign w_sum = PSUM_WIDTH'(sat_add(c_SAT_W'(signed'(psum_in)),
                                       c_SAT_W'(signed'(w_in_head)),
                                       PSUM_WIDTH, SATURATE != 0));

    // Mode is decoded each cycle. Only the pipe entry loaded this cycle is
    // affected by the current mode.
    always_comb begin
        psum_ready  = 1'b0;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        w_load_data = psum_in;
        case (mode)
            MODE_PASS: begin
                psum_ready = w_room;
                w_load     = psum_valid & w_room;
            end
            MODE_ACC: begin
                psum_ready  = w_room & ~inpsum_empty;
                w_load      = psum_valid & w_room & ~inpsum_empty;
                w_pop       = psum_valid & w_room & ~inpsum_empty;
                w_load_data = w_sum;
            end
            MODE_DRAIN: begin
                w_load      = w_room & ~inpsum_empty;
                w_pop       = w_room & ~inpsum_empty;
                w_load_data = w_in_head;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_valid <= 1'b0;
            r_pipe_data  <= '0;
        end else begin
            r_pipe_valid <= w_load;
            if (w_load) begin
                r_pipe_data <= w_load_data;
            end
        end
    end

    psum_fifo #(
        .WIDTH  (PSUM_WIDTH),
        .DEPTH  (IN_DEPTH),
        .RD_PAR (1),
        .FWFT   (1)
    ) u_in_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wen   (inpsum_wen),
        .i_din   (inpsum_din),
        .i_ren   (w_pop),
        .o_dout  (w_in_head),
        .o_count (w_in_count)
    );

    psum_fifo #(
        .WIDTH  (PSUM_WIDTH),
        .DEPTH  (OUT_DEPTH),
        .RD_PAR (OUT_PAR),
        .FWFT   (0)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wen   (r_pipe_valid),
        .i_din   (r_pipe_data),
        .i_ren   (outbuf_ren),
        .o_dout  (outbuf_dout),
        .o_count (out_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_psum_accum_outbuf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_accum_outbuf
//  Description : Self-checking bench for psum_accum_outbuf. The default
//                instance is compared every cycle against a queue-based
//                reference model. Two narrow 8-bit instances check the
//                parallel-read and saturate/wrap cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_accum_outbuf;
    import psum_pkg::*;

    localparam int W  = 33;
    localparam int ID = 64;
    localparam int OD = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default instance (A)
    logic [1:0]   a_mode;
    logic         a_pv, a_pr, a_iw, a_ifull, a_iempty, a_ren, a_ofull, a_oempty;
    logic [W-1:0] a_pin, a_idin, a_dout;
    logic [6:0]   a_cnt;

    // OUT_PAR=2, 8-bit, saturating (B)
    logic [1:0]   b_mode;
    logic         b_pv, b_pr, b_iw, b_ifull, b_iempty, b_ren, b_ofull, b_oempty;
    logic [7:0]   b_pin, b_idin;
    logic [15:0]  b_dout;
    logic [3:0]   b_cnt;

    // OUT_PAR=1, 8-bit, wrapping (C)
    logic [1:0]   c_mode;
    logic         c_pv, c_pr, c_iw, c_ifull, c_iempty, c_ren, c_ofull, c_oempty;
    logic [7:0]   c_pin, c_idin, c_dout;
    logic [3:0]   c_cnt;

    psum_accum_outbuf u_dut_a (
        .clk(clk), .rst(rst), .mode(a_mode), .psum_valid(a_pv), .psum_in(a_pin),
        .psum_ready(a_pr), .inpsum_wen(a_iw), .inpsum_din(a_idin),
        .inpsum_full(a_ifull), .inpsum_empty(a_iempty), .outbuf_ren(a_ren),
        .outbuf_dout(a_dout), .outbuf_full(a_ofull), .outbuf_empty(a_oempty),
        .out_count(a_cnt)
    );

    psum_accum_outbuf #(.PSUM_WIDTH(8), .IN_DEPTH(8), .OUT_DEPTH(8),
                        .OUT_PAR(2), .SATURATE(1)) u_dut_b (
        .clk(clk), .rst(rst), .mode(b_mode), .psum_valid(b_pv), .psum_in(b_pin),
        .psum_ready(b_pr), .inpsum_wen(b_iw), .inpsum_din(b_idin),
        .inpsum_full(b_ifull), .inpsum_empty(b_iempty), .outbuf_ren(b_ren),
        .outbuf_dout(b_dout), .outbuf_full(b_ofull), .outbuf_empty(b_oempty),
        .out_count(b_cnt)
    );

    psum_accum_outbuf #(.PSUM_WIDTH(8), .IN_DEPTH(8), .OUT_DEPTH(8),
                        .OUT_PAR(1), .SATURATE(0)) u_dut_c (
        .clk(clk), .rst(rst), .mode(c_mode), .psum_valid(c_pv), .psum_in(c_pin),
        .psum_ready(c_pr), .inpsum_wen(c_iw), .inpsum_din(c_idin),
        .inpsum_full(c_ifull), .inpsum_empty(c_iempty), .outbuf_ren(c_ren),
        .outbuf_dout(c_dout), .outbuf_full(c_ofull), .outbuf_empty(c_oempty),
        .out_count(c_cnt)
    );

    int checks = 0;
    int errors = 0;

    // reference model state for instance A
    logic [W-1:0] m_in[$];
    logic [W-1:0] m_out[$];
    logic         m_pv;
    logic [W-1:0] m_pval;
    logic [W-1:0] m_dout;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] s33(input int v);
        s33 = W'(v);
    endfunction

    // One clock cycle on instance A. The task is entered at a falling edge.
    // It applies the inputs, compares every output with the model, moves the
    // model forward over the coming rising edge, and then returns at the
    // next falling edge.
    task automatic step_a(input logic [1:0] m, input logic pv, input logic [W-1:0] pin,
                          input logic iw, input logic [W-1:0] idin, input logic ren,
                          output logic acc);
        logic         room, iempty, rdy;
        logic [W-1:0] val;
        a_mode = m; a_pv = pv; a_pin = pin; a_iw = iw; a_idin = idin; a_ren = ren;
        #1;
        iempty = (m_in.size() == 0);
        room   = (m_out.size() + int'(m_pv)) < OD;
        case (m)
            MODE_PASS: rdy = room;
            MODE_ACC:  rdy = room && !iempty;
            default:   rdy = 1'b0;
        endcase
        chk("psum_ready",   a_pr,     rdy);
        chk("inpsum_empty", a_iempty, iempty);
        chk("inpsum_full",  a_ifull,  m_in.size() == ID);
        chk("outbuf_full",  a_ofull,  !room);
        chk("outbuf_empty", a_oempty, m_out.size() < 1);
        chk("out_count",    a_cnt,    m_out.size());
        chk("outbuf_dout",  a_dout,   m_dout);
        acc = (m == MODE_DRAIN) ? (room && !iempty) : (pv && rdy);
        val = pin;
        if (acc && m == MODE_ACC)   val = pin + m_in[0];
        if (acc && m == MODE_DRAIN) val = m_in[0];
        if (ren && m_out.size() > 0) m_dout = m_out.pop_front();
        if (m_pv) m_out.push_back(m_pval);
        if (acc && m != MODE_PASS) void'(m_in.pop_front());
        if (iw && m_in.size() < ID) m_in.push_back(idin);
        m_pv   = acc;
        m_pval = val;
        @(negedge clk);
    endtask

    task automatic idle_a(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step_a(MODE_HOLD, 0, '0, 0, '0, 0, acc);
    endtask

    task automatic reset_all();
        rst = 1'b1;
        a_mode = MODE_HOLD; a_pv = 0; a_iw = 0; a_ren = 0;
        b_mode = MODE_HOLD; b_pv = 0; b_iw = 0; b_ren = 0;
        c_mode = MODE_HOLD; c_pv = 0; c_iw = 0; c_ren = 0;
        @(negedge clk);
        rst = 1'b0;
        m_in.delete(); m_out.delete(); m_pv = 0; m_pval = '0; m_dout = '0;
        #1;
        chk("rst_out_count",    a_cnt,    0);
        chk("rst_inpsum_empty", a_iempty, 1);
        chk("rst_outbuf_empty", a_oempty, 1);
        chk("rst_outbuf_dout",  a_dout,   0);
        chk("rst_outbuf_full",  a_ofull,  0);
        chk("rst_inpsum_full",  a_ifull,  0);
        @(negedge clk);
    endtask

    initial begin
        logic acc;
        logic [W-1:0] v;
        a_pin = '0; a_idin = '0; b_pin = '0; b_idin = '0; c_pin = '0; c_idin = '0;
        reset_all();

        // ---- B: OUT_PAR=2 packing, empty read hold ----
        b_mode = MODE_PASS; b_pv = 1; b_pin = 8'd1;
        @(negedge clk); b_pin = 8'd2;
        @(negedge clk); b_pin = 8'd3;
        chk("b_count1", b_cnt, 1);
        chk("b_empty_at1", b_oempty, 1);
        @(negedge clk); b_pv = 0;
        chk("b_count2", b_cnt, 2);
        chk("b_empty_at2", b_oempty, 0);
        b_ren = 1;
        @(negedge clk); b_ren = 0;
        chk("b_read_pair", b_dout, 16'h0201);
        chk("b_count_after_read", b_cnt, 1);
        chk("b_empty_after_read", b_oempty, 1);
        b_ren = 1;
        @(negedge clk); b_ren = 0;
        chk("b_empty_read_hold", b_dout, 16'h0201);
        chk("b_empty_read_count", b_cnt, 1);

        // ---- B: saturating accumulate ----
        b_mode = MODE_HOLD; b_iw = 1; b_idin = 8'd100;
        @(negedge clk); b_idin = 8'h9C;   // -100
        @(negedge clk); b_idin = 8'd50;
        @(negedge clk); b_iw = 0;
        b_mode = MODE_ACC; b_pv = 1; b_pin = 8'd100;
        #1 chk("b_acc_ready", b_pr, 1);
        @(negedge clk); b_pin = 8'h9C;    // -100
        @(negedge clk); b_pin = 8'hEC;    // -20
        @(negedge clk); b_pv = 0; b_mode = MODE_HOLD;
        @(negedge clk);
        chk("b_inpsum_drained", b_iempty, 1);
        chk("b_count_sat", b_cnt, 4);
        b_ren = 1;
        @(negedge clk);
        chk("b_sat_pos", b_dout, 16'h7F03);
        @(negedge clk); b_ren = 0;
        chk("b_sat_neg_and_normal", b_dout, 16'h1E80);

        // ---- C: wrapping accumulate at 8 bits ----
        c_mode = MODE_HOLD; c_iw = 1; c_idin = 8'd100;
        @(negedge clk); c_idin = 8'd50;
        @(negedge clk); c_iw = 0;
        c_mode = MODE_ACC; c_pv = 1; c_pin = 8'd100;
        @(negedge clk); c_pin = 8'hEC;    // -20
        @(negedge clk); c_pv = 0; c_mode = MODE_HOLD;
        @(negedge clk); c_ren = 1;
        @(negedge clk);
        chk("c_wrap", c_dout, 8'hC8);     // -56
        @(negedge clk); c_ren = 0;
        chk("c_normal", c_dout, 8'h1E);

        // ---- A: accumulate ----
        reset_all();
        step_a(MODE_HOLD, 0, '0, 1, s33(100), 0, acc);
        step_a(MODE_HOLD, 0, '0, 1, s33(-50), 0, acc);
        step_a(MODE_ACC, 1, s33(-2482), 0, '0, 0, acc);
        step_a(MODE_ACC, 1, s33(7649), 0, '0, 0, acc);
        chk("t1_inpsum_empty", a_iempty, 1);
        step_a(MODE_ACC, 1, s33(5), 0, '0, 0, acc);
        chk("t1_ready_drop", a_pr, 0);
        step_a(MODE_HOLD, 0, '0, 0, '0, 1, acc);
        chk("t1_out0", a_dout, s33(-2382));
        step_a(MODE_HOLD, 0, '0, 0, '0, 1, acc);
        chk("t1_out1", a_dout, s33(7599));

        // ---- A: drain, then drain interrupted by hold ----
        reset_all();
        step_a(MODE_HOLD, 0, '0, 1, s33(7), 0, acc);
        step_a(MODE_HOLD, 0, '0, 1, s33(-9), 0, acc);
        step_a(MODE_HOLD, 0, '0, 1, s33(11), 0, acc);
        for (int i = 0; i < 3; i++) step_a(MODE_DRAIN, 1, s33(1), 0, '0, 0, acc);
        idle_a(2);
        chk("t5_drain_count", a_cnt, 3);
        step_a(MODE_HOLD, 0, '0, 1, s33(7), 0, acc);
        step_a(MODE_HOLD, 0, '0, 1, s33(-9), 0, acc);
        step_a(MODE_HOLD, 0, '0, 1, s33(11), 0, acc);
        step_a(MODE_DRAIN, 0, '0, 0, '0, 0, acc);
        step_a(MODE_DRAIN, 0, '0, 0, '0, 0, acc);
        idle_a(3);
        chk("t5_hold_count", a_cnt, 5);
        chk("t5_hold_left", a_iempty, 0);
        for (int i = 0; i < 5; i++) step_a(MODE_HOLD, 0, '0, 0, '0, 1, acc);

        // ---- A: reset with data stored and one result in flight ----
        for (int i = 0; i < 6; i++) step_a(MODE_PASS, 1, s33(200 + i), 1, s33(i), 0, acc);
        reset_all();
        idle_a(3);

        // ---- A: fill output FIFO ----
        for (int i = 0; i < 64; i++) step_a(MODE_PASS, 1, s33(1000 + i), 0, '0, 0, acc);
        chk("t2_full", a_ofull, 1);
        chk("t2_ready_low", a_pr, 0);
        step_a(MODE_PASS, 1, s33(2000), 0, '0, 0, acc);
        step_a(MODE_PASS, 1, s33(2000), 0, '0, 1, acc);
        chk("t2_first_word", a_dout, s33(1000));
        acc = 1'b0;
        for (int i = 0; i < 5 && !acc; i++) step_a(MODE_PASS, 1, s33(2000), 0, '0, 0, acc);

        // ---- A: randomized traffic against the model ----
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 400; i++) begin
                logic [1:0] m;
                logic       pv, iw, ren;
                logic [W-1:0] pin, idin;
                pin  = {1'($urandom_range(1, 0)), 32'($urandom)};
                idin = {1'($urandom_range(1, 0)), 32'($urandom)};
                pv   = 1'($urandom_range(3, 0) != 0);
                if (ph == 1) begin
                    m   = $urandom_range(1, 0) != 0 ? MODE_PASS : MODE_HOLD;
                    iw  = 1'($urandom_range(9, 0) != 0);
                    ren = 1'($urandom_range(9, 0) == 0);
                end else begin
                    m   = 2'($urandom_range(3, 0));
                    iw  = 1'($urandom_range(1, 0));
                    ren = (ph == 2) ? 1'($urandom_range(9, 0) != 0) : 1'($urandom_range(1, 0));
                end
                step_a(m, pv, pin, iw, idin, ren, acc);
            end
        end
        v = '0;
        idle_a(2);
        while (m_out.size() > 0 && v < 200) begin
            step_a(MODE_HOLD, 0, '0, 0, '0, 1, acc);
            v = v + 1;
        end
        chk("final_drained", a_oempty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/psum_accum_outbuf.md
Name: psum_accum_outbuf

Overview:
Output-side psum merge stage of the conv accelerator. It sits between the PE psum scratchpad and the host-readable output buffer. Each PE psum is either passed straight to the output FIFO or added to a previously loaded input psum popped from an internal input-psum FIFO. The block generalises the earlier fixed 1-wide outbuf/inpsum pair with configurable width, depths, parallel read width and saturating arithmetic.

Parameters:
PSUM_WIDTH, 33, psum word width (FILT_SCRATCH_WIDTH + IF_SCRATCH_WIDTH + 1), two's complement
IN_DEPTH, 64, input-psum FIFO depth; power of two
OUT_DEPTH, 64, output FIFO depth; power of two, multiple of OUT_PAR
OUT_PAR, 1, words returned per output read
SATURATE, 0, 1 = clamp sums to signed range; 0 = wrap

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mode  in  2  0 pass, 1 accumulate, 2 drain inpsum, 3 hold
psum_valid  in  1  PE psum offered
psum_in  in  PSUM_WIDTH  PE psum
psum_ready  out  1  psum accepted when valid & ready
inpsum_wen  in  1  push input psum
inpsum_din  in  PSUM_WIDTH  input psum
inpsum_full  out  1  input FIFO full
inpsum_empty  out  1  input FIFO empty
outbuf_ren  in  1  pop OUT_PAR words
outbuf_dout  out  OUT_PAR*PSUM_WIDTH  popped words; oldest in LSBs
outbuf_full  out  1  no room for another result
outbuf_empty  out  1  fewer than OUT_PAR words stored
out_count  out  $clog2(OUT_DEPTH)+1  words stored in output FIFO

Behaviour:
- Reset (synchronous): all pointers and counts cleared, pipeline stage invalid, outbuf_dout = 0, inpsum_empty = 1, outbuf_empty = 1, full flags 0. A reset asserted mid-operation discards all stored data and any in-flight result.
- Datapath has one pipeline register between accept and output-FIFO write. A result accepted in cycle N is written at edge N+1 and is counted in out_count from cycle N+2.
- room = (out_count + pipe_valid) < OUT_DEPTH. outbuf_full = ~room.
- psum_ready by mode:
  - mode 0: room.
  - mode 1: room & ~inpsum_empty.
  - mode 2 and mode 3: 0.
- Mode 1 accept: pops one input psum in the same cycle and registers psum_in + inpsum_head.
- Mode 2, no handshake: each cycle with room & ~inpsum_empty, pops the input-psum head into the pipe unchanged.
- Mode 3 freezes the writer. Reads and input-psum pushes still work.
- Mode is sampled per accept. A change of mode never alters an entry already in the pipe.
- Arithmetic: full-width signed add.
  - SATURATE=0: wrap modulo 2^PSUM_WIDTH.
  - SATURATE=1: positive overflow gives 2^(W-1)-1; negative overflow gives -2^(W-1).
- Input psum FIFO:
  - A push when inpsum_full is ignored.
  - A push and a pop in the same cycle are both legal, including when the FIFO is full: the pop frees the slot.
  - A push into an empty FIFO is poppable the next cycle.
- Output read:
  - outbuf_ren with ~outbuf_empty pops OUT_PAR words. outbuf_dout is registered and updated at that edge.
  - outbuf_ren while empty is ignored and outbuf_dout holds its value.
  - A simultaneous pipe write and read are both performed; out_count changes by +1-OUT_PAR.
- Pointers wrap naturally at depth. Full and empty are derived from the counts, never from pointer equality alone.

Decomposition:
- Package psum_pkg holds:
  - mode constants MODE_PASS=0, MODE_ACC=1, MODE_DRAIN=2, MODE_HOLD=3.
  - the sat_add function, parametrised by width.
- One sub-module, psum_fifo: synchronous FIFO with WIDTH, DEPTH and RD_PAR parameters, count output and registered dout.
  - Instantiated twice: input FIFO with RD_PAR=1, output FIFO with RD_PAR=OUT_PAR.
  - The input FIFO presents its head combinationally (first-word fall-through) for the adder.
- Top-level logic is the ready/mode decode and the pipe register.

Test Plan:
1. Mode 1 accumulate: push inpsum {100, -50}, then psums {-2482, 7649}. Outputs must be {-2382, 7599}, inpsum_empty must read 1 afterwards, and psum_ready must drop with a third psum pending.
2. Mode 0, 64 psums with no reads: outbuf_full must assert once the 64th psum is accepted and psum_ready must be 0; the 65th psum is held. One read then lets it in two cycles later.
3. OUT_PAR=2, mode 0, psums 1, 2, 3:
   - outbuf_empty deasserts when out_count = 2.
   - A read returns {2,1} with 1 in the LSBs, and out_count becomes 1.
   - outbuf_empty = 1 after the read.
   - A read while empty leaves outbuf_dout unchanged.
4. SATURATE=1, PSUM_WIDTH=8, mode 1: 100+100 must give 127, -100+-100 must give -128, 50+-20 must give 30. With SATURATE=0, 100+100 must give -56.
5. Mode 2 drain: preload inpsum {7, -9, 11}. The output FIFO must receive 7, -9, 11 on consecutive cycles with psum_ready = 0 throughout. Switching to mode 3 mid-drain stops further pops, but the in-flight value is still written.
6. Reset mid-operation: after 5 writes plus one in-flight, assert rst for 1 cycle. out_count must be 0, both empty flags 1, outbuf_dout 0, and no stale word may appear afterwards.
